stack_arbiter: RTL and testbench

- Shares one LIFO stack (WIDTH-bit entries, DEPTH deep, push/pop strobes, registered top-of-stack output) between two requesters.
- Round-robin arbitration; one operation in flight at a time.
- Owns the authoritative occupancy count and full/empty flags, and rejects illegal operations before they reach the stack.
- Sits between the path/backtrack control units and the stack instance.

---
 rtl/stack_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_stack_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//
// Purpose:
//   Shares one LIFO stack between two requesters. Requests are granted
//   round-robin with one operation in flight at a time. The arbiter keeps the
//   authoritative occupancy count and full/empty flags, and rejects illegal
//   operations (push when full, pop when empty) before they reach the stack.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   req0/op0/din0       requester 0 request (held until ack0), op (1=push,
//                       0=pop), push data
//   ack0/err0           requester 0 one-cycle completion pulse / reject flag
//   req1/op1/din1       requester 1 request, op, push data
//   ack1/err1           requester 1 completion pulse / reject flag
//   rsp_data/rsp_valid  popped value and its one-cycle valid pulse
//   rsp_id              requester that owns rsp_data
//   stk_push/stk_pop    one-cycle strobes to the stack
//   stk_din             push data to the stack
//   stk_dout            stack top-of-stack output (holds popped entry the
//                       cycle after the pop edge)
//   count/full/empty    occupancy and its decoded flags
//
// States:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | arbitrate; latch grant; issue strobe or reject
//   S_ISSUE    | strobe visible; stack acts on closing edge; count updates
//   S_POP_WAIT | stk_dout holds popped entry; capture it into rsp_data
//   S_ACK      | ack/err/rsp_valid visible for exactly this cycle
// -----------------------------------------------------------------------------
module stack_arbiter #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 256,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] din0,
    output logic             ack0,
    output logic             err0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] din1,
    output logic             ack1,
    output logic             err1,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_POP_WAIT = 2'd2,
        S_ACK      = 2'd3
    } state_t;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_last;      // id granted most recently
    logic              r_gnt_id;
    logic              r_gnt_op;
    logic [CW-1:0]     r_count;
    logic              r_ack0, r_ack1, r_err0, r_err1;
    logic              r_rsp_valid, r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_stk_push, r_stk_pop;
    logic [WIDTH-1:0]  r_stk_din;

    logic              w_last_nxt, w_gnt_id_nxt, w_gnt_op_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic              w_ack0_nxt, w_ack1_nxt, w_err0_nxt, w_err1_nxt;
    logic              w_rsp_valid_nxt, w_rsp_id_nxt;
    logic [WIDTH-1:0]  w_rsp_data_nxt;
    logic              w_stk_push_nxt, w_stk_pop_nxt;
    logic [WIDTH-1:0]  w_stk_din_nxt;

    logic              w_req_any;
    logic              w_gnt_id;
    logic              w_op;
    logic [WIDTH-1:0]  w_din;
    logic              w_full, w_empty;
    logic              w_legal;

    // Arbitration: a lone requester wins outright; on contention the
    // requester not granted last wins. r_last resets to 1 so 0 wins first.
    assign w_req_any = req0 | req1;
    assign w_gnt_id  = (req0 & req1) ? ~r_last : req1;
    assign w_op      = w_gnt_id ? op1  : op0;
    assign w_din     = w_gnt_id ? din1 : din0;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_legal   = w_op ? ~w_full : ~w_empty;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_gnt_id    <= 1'b0;
            r_gnt_op    <= 1'b0;
            r_count     <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_stk_push  <= 1'b0;
            r_stk_pop   <= 1'b0;
            r_stk_din   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_op    <= w_gnt_op_nxt;
            r_count     <= w_count_nxt;
            r_ack0      <= w_ack0_nxt;
            r_ack1      <= w_ack1_nxt;
            r_err0      <= w_err0_nxt;
            r_err1      <= w_err1_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_stk_push  <= w_stk_push_nxt;
            r_stk_pop   <= w_stk_pop_nxt;
            r_stk_din   <= w_stk_din_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = w_legal ? S_ISSUE : S_ACK;
                end
            end
            S_ISSUE:    w_state_nxt = r_gnt_op ? S_ACK : S_POP_WAIT;
            S_POP_WAIT: w_state_nxt = S_ACK;
            S_ACK:      w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; pulses default low so each lasts a cycle
    always_comb begin
        w_last_nxt      = r_last;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_op_nxt    = r_gnt_op;
        w_count_nxt     = r_count;
        w_ack0_nxt      = 1'b0;
        w_ack1_nxt      = 1'b0;
        w_err0_nxt      = 1'b0;
        w_err1_nxt      = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_data_nxt  = r_rsp_data;
        w_stk_push_nxt  = 1'b0;
        w_stk_pop_nxt   = 1'b0;
        w_stk_din_nxt   = r_stk_din;

        unique case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    // Pointer moves on every grant, rejected ones included
                    w_last_nxt   = w_gnt_id;
                    w_gnt_id_nxt = w_gnt_id;
                    w_gnt_op_nxt = w_op;
                    if (w_legal) begin
                        if (w_op) begin
                            w_stk_push_nxt = 1'b1;
                            w_stk_din_nxt  = w_din;
                        end else begin
                            w_stk_pop_nxt  = 1'b1;
                        end
                    end else if (w_gnt_id) begin
                        w_ack1_nxt = 1'b1;
                        w_err1_nxt = 1'b1;
                    end else begin
                        w_ack0_nxt = 1'b1;
                        w_err0_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (r_gnt_op) begin
                    w_count_nxt = r_count + CW'(1);
                    w_ack0_nxt  = ~r_gnt_id;
                    w_ack1_nxt  = r_gnt_id;
                end else begin
                    w_count_nxt = r_count - CW'(1);
                end
            end
            S_POP_WAIT: begin
                w_rsp_data_nxt  = stk_dout;
                w_rsp_id_nxt    = r_gnt_id;
                w_rsp_valid_nxt = 1'b1;
                w_ack0_nxt      = ~r_gnt_id;
                w_ack1_nxt      = r_gnt_id;
            end
            default: ;
        endcase
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign stk_push  = r_stk_push;
    assign stk_pop   = r_stk_pop;
    assign stk_din   = r_stk_din;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    localparam int WIDTH = 2;
    localparam int DEPTH = 256;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, op0, req1, op1;
    logic [WIDTH-1:0] din0, din1;
    logic             ack0, err0, ack1, err1;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_valid, rsp_id;
    logic             stk_push, stk_pop;
    logic [WIDTH-1:0] stk_din;
    logic [WIDTH-1:0] stk_dout;
    logic [CW-1:0]    count;
    logic             full, empty;

    stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .op0(op0), .din0(din0), .ack0(ack0), .err0(err0),
        .req1(req1), .op1(op1), .din1(din1), .ack1(ack1), .err1(err1),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Attached stack: registered top-of-stack, reset together with the arbiter
    logic [WIDTH-1:0] smem [0:DEPTH-1];
    int               sp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp       <= 0;
            stk_dout <= '0;
        end else if (stk_push && sp < DEPTH) begin
            smem[sp] <= stk_din;
            sp       <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_dout <= smem[sp-1];
            sp       <= sp - 1;
        end
    end

    // Activity monitors
    int               n_push = 0, n_pop = 0, n_both = 0, n_ack = 0, n_rsp = 0;
    logic [WIDTH-1:0] last_din = '0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (stk_push) begin n_push <= n_push + 1; last_din <= stk_din; end
            if (stk_pop)  n_pop  <= n_pop + 1;
            if (stk_push && stk_pop) n_both <= n_both + 1;
            if (ack0) n_ack <= n_ack + 1;
            if (ack1) n_ack <= n_ack + 1 + (ack0 ? 1 : 0);
            if (rsp_valid) n_rsp <= n_rsp + 1;
        end
    end

    // Reference model: stack contents, round-robin memory, expected totals
    logic [WIDTH-1:0] m_stk[$];
    bit               m_last = 1'b1;
    int               m_ops  = 0;
    int               m_rsps = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic start(input bit id, input bit op, input logic [WIDTH-1:0] d);
        if (id) begin req1 = 1'b1; op1 = op; din1 = d; end
        else    begin req0 = 1'b1; op0 = op; din0 = d; end
    endtask

    // Waits for the ack of an already-requested op and checks its outcome.
    // extra = idle cycles expected before this op's grant edge.
    task automatic finish(input bit id, input bit op, input logic [WIDTH-1:0] d,
                          input int extra);
        bit               legal;
        int               cyc, ps0, pp0, exp_lat;
        logic [WIDTH-1:0] exp_top;
        legal   = op ? (m_stk.size() < DEPTH) : (m_stk.size() > 0);
        exp_lat = extra + (!legal ? 1 : (op ? 2 : 3));
        ps0 = n_push;
        pp0 = n_pop;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == extra + 1) begin   // after grant: op/din must be ignored
                if (id) begin op1 = $urandom; din1 = $urandom; end
                else    begin op0 = $urandom; din0 = $urandom; end
            end
        end while (!(ack0 || ack1) && cyc < 20);
        chk("latency", cyc, exp_lat);
        chk("ack_owner", id ? ack1 : ack0, 1);
        chk("ack_other", id ? ack0 : ack1, 0);
        chk("err", id ? err1 : err0, !legal);
        chk("push_strobes", n_push - ps0, (legal && op) ? 1 : 0);
        chk("pop_strobes", n_pop - pp0, (legal && !op) ? 1 : 0);
        if (legal && op) begin
            chk("stk_din", last_din, d);
            m_stk.push_back(d);
        end
        if (legal && !op) begin
            exp_top = m_stk.pop_back();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, exp_top);
            chk("rsp_id", rsp_id, id);
            m_rsps++;
        end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
        end
        chk("count", count, m_stk.size());
        chk("full", full, m_stk.size() == DEPTH);
        chk("empty", empty, m_stk.size() == 0);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        m_last = id;
        m_ops++;
    endtask

    task automatic single(input bit id, input bit op, input logic [WIDTH-1:0] d);
        @(negedge clk);
        start(id, op, d);
        finish(id, op, d, 0);
    endtask

    task automatic pair(input bit op_a, input logic [WIDTH-1:0] d_a,
                        input bit op_b, input logic [WIDTH-1:0] d_b);
        bit w;
        @(negedge clk);
        start(1'b0, op_a, d_a);
        start(1'b1, op_b, d_b);
        w = ~m_last;
        if (w) begin
            finish(1'b1, op_b, d_b, 0);
            finish(1'b0, op_a, d_a, 1);
        end else begin
            finish(1'b0, op_a, d_a, 0);
            finish(1'b1, op_b, d_b, 1);
        end
    endtask

    int saved_ack;

    initial begin
        rst_n = 1'b0;
        req0 = 0; op0 = 0; din0 = 0;
        req1 = 0; op1 = 0; din1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First contended grant after reset goes to requester 0, then alternates
        for (int i = 0; i < 4; i++) pair(1'b1, WIDTH'($urandom), 1'b1, WIDTH'($urandom));
        for (int i = 0; i < 8; i++) single(1'b0, 1'b0, '0);

        // Pop at empty is rejected
        single(1'b0, 1'b0, '0);
        single(1'b1, 1'b0, '0);

        // Push 2 from empty, push 3 then 1 via requester 1, pops via requester 0
        single(1'b0, 1'b1, 2'b10);
        single(1'b1, 1'b1, 2'd3);
        single(1'b1, 1'b1, 2'd1);
        single(1'b0, 1'b0, '0);
        single(1'b0, 1'b0, '0);
        single(1'b0, 1'b0, '0);

        // Randomized mix of single and contended operations
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                pair($urandom_range(0, 2) != 0, WIDTH'($urandom),
                     $urandom_range(0, 2) != 0, WIDTH'($urandom));
            else
                single(1'($urandom), $urandom_range(0, 1) == 1, WIDTH'($urandom));
        end

        // Fill to capacity, reject the next push, then pop once
        while (m_stk.size() < DEPTH) single(1'($urandom), 1'b1, WIDTH'($urandom));
        single(1'b0, 1'b1, 2'd3);
        pair(1'b1, 2'd1, 1'b1, 2'd2);
        single(1'b1, 1'b0, '0);
        chk("after_full_pop_count", count, DEPTH - 1);

        // Drain to empty
        while (m_stk.size() > 0) single(1'($urandom), 1'b0, '0);
        single(1'b1, 1'b0, '0);

        // Reset in the middle of a pop with five entries stacked
        for (int i = 0; i < 5; i++) single(1'b1, 1'b1, WIDTH'($urandom));
        @(negedge clk);
        start(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("pop_strobe_before_reset", stk_pop, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_acks", {ack0, ack1, err0, err1}, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
        chk("mid_rst_stk", {stk_push, stk_pop, stk_din}, 0);
        chk("mid_rst_empty", empty, 1);
        req0 = 1'b0;
        m_stk.delete();
        m_last = 1'b1;
        saved_ack = n_ack;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_ack_after_reset", n_ack, saved_ack);
        pair(1'b1, 2'd2, 1'b0, '0);

        @(negedge clk);
        chk("total_acks", n_ack, m_ops);
        chk("total_rsp", n_rsp, m_rsps);
        chk("strobe_overlap", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d comparisons expected completion", n_cmp);
        $fatal(1);
    end

endmodule
